// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the two-port SDRAM arbiter (sdram_port_arb).
package sdram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_ADDR_W    = 25;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_TAG_DEPTH = 4;

  // Identifies which requester (0 or 1) owns a command or a read tag.
  typedef logic req_id_t;

  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding reads; one entry per accepted read.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_TAG_DEPTH
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  req_id_t push_id_i,
  input  logic    pop_i,
  output req_id_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE      = (PW+1)'(1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  req_id_t       mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push while full is only taken when a pop frees the slot in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + ONE;
    else if (!do_push && do_pop) count_d = count_q - ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Two-requester Avalon-MM arbiter in front of one SDRAM controller slave.
// Define SDRAM_ARB_FIXED_PRIO_EN to make requester 0 always win contention (default: round-robin).
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic                clk_clk,
  input  logic                reset_reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,

  output logic                err,
  output logic                dbg_state_o,
  output logic                dbg_grant_o
);

  // Handshake: a command moves when s_read|s_write is high and s_waitrequest is low
  // in the same cycle; the granted requester sees s_waitrequest as its own stall.

  arb_state_e state_q, state_d;
  req_id_t    grant_q, grant_d;
  logic       err_q;

  logic [ADDR_W-1:0]   addr_hold_q;
  logic [DATA_W-1:0]   wdata_hold_q;
  logic [DATA_W/8-1:0] be_hold_q;

  logic                busy, accept;
  logic                elig0, elig1;
  req_id_t             pick;
  logic                g_read, g_write;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;
  logic [DATA_W/8-1:0] g_be;

  logic    fifo_push, fifo_pop, fifo_full, fifo_empty;
  req_id_t fifo_head;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign pick = 1'b0;
`else
  req_id_t ptr_q, ptr_d;
  assign pick = ptr_q;
`endif

  assign busy = (state_q == BUSY);

  assign g_read  = grant_q ? m1_read       : m0_read;
  assign g_write = grant_q ? m1_write      : m0_write;
  assign g_addr  = grant_q ? m1_address    : m0_address;
  assign g_wdata = grant_q ? m1_writedata  : m0_writedata;
  assign g_be    = grant_q ? m1_byteenable : m0_byteenable;

  // Reads need a free tag slot; writes never return data so they stay eligible.
  assign elig0 = m0_write || (m0_read && !fifo_full);
  assign elig1 = m1_write || (m1_read && !fifo_full);

  assign s_read       = busy && g_read;
  assign s_write      = busy && g_write;
  assign s_address    = busy ? g_addr  : addr_hold_q;
  assign s_writedata  = busy ? g_wdata : wdata_hold_q;
  assign s_byteenable = busy ? g_be    : be_hold_q;

  assign accept = busy && (s_read || s_write) && !s_waitrequest;

  assign m0_waitrequest = !(busy && (grant_q == 1'b0)) || s_waitrequest;
  assign m1_waitrequest = !(busy && (grant_q == 1'b1)) || s_waitrequest;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (elig0 && elig1) begin
          grant_d = pick;
          state_d = BUSY;
        end else if (elig0) begin
          grant_d = 1'b0;
          state_d = BUSY;
        end else if (elig1) begin
          grant_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          state_d = IDLE;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
          ptr_d   = other_req(grant_q);
`endif
        end else if (!g_read && !g_write) begin
          // Requester withdrew its command; release the port rather than lock up.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      err_q        <= 1'b0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      be_hold_q    <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      ptr_q        <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (s_readdatavalid && fifo_empty) err_q <= 1'b1;
      if (busy) begin
        addr_hold_q  <= g_addr;
        wdata_hold_q <= g_wdata;
        be_hold_q    <= g_be;
      end
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      ptr_q <= ptr_d;
`endif
    end
  end

  assign fifo_push = accept && s_read;
  assign fifo_pop  = s_readdatavalid;

  sdram_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i     (clk_clk),
    .rst_i     (reset_reset),
    .push_i    (fifo_push),
    .push_id_i (grant_q),
    .pop_i     (fifo_pop),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Return data is routed by the oldest outstanding tag; stray returns are dropped.
  assign m0_readdatavalid = s_readdatavalid && !fifo_empty && (fifo_head == 1'b0);
  assign m1_readdatavalid = s_readdatavalid && !fifo_empty && (fifo_head == 1'b1);
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

  assign err         = err_q;
  assign dbg_state_o = state_q;
  assign dbg_grant_o = grant_q;

endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 Parameter ADDR_W, default 25, SDRAM controller word-address width (13 row + 10 col + 2 bank).
REQ-002 Parameter DATA_W, default 16, data width; byteenable width is DATA_W/8.
REQ-003 Parameter TAG_DEPTH, default 4, maximum outstanding reads (power of two, 2..16).
REQ-004 clk_clk  in  1  single clock for all logic.
REQ-005 reset_reset  in  1  reset, synchronous, active-high.
REQ-006 mN_address  in  ADDR_W  requester N (N=0,1) word address.
REQ-007 mN_read / mN_write  in  1 each  requester N command strobes; both high is illegal.
REQ-008 mN_writedata / mN_byteenable  in  DATA_W / DATA_W/8  requester N write payload.
REQ-009 mN_waitrequest  out  1  requester N stall, Avalon-MM semantics.
REQ-010 mN_readdata / mN_readdatavalid  out  DATA_W / 1  requester N read return.
REQ-011 s_address, s_read, s_write, s_writedata, s_byteenable  out  as mN_*  command to SDRAM controller slave.
REQ-012 s_waitrequest, s_readdata, s_readdatavalid  in  1, DATA_W, 1  SDRAM controller responses.
REQ-013 err  out  1  sticky flag: s_readdatavalid arrived with no outstanding read.

Function
REQ-014 States IDLE and BUSY; IDLE with any eligible request -> BUSY next cycle, grant registered.
REQ-015 Eligible: mN_write high, or mN_read high with tag FIFO not full.
REQ-016 Both eligible in IDLE: grant to requester indicated by round-robin pointer; one eligible: grant it.
REQ-017 In BUSY, s_* command outputs mirror the granted requester; non-granted requester sees mN_waitrequest=1.
REQ-018 Granted mN_waitrequest = s_waitrequest in BUSY; 1 in IDLE.
REQ-019 Command accepted when BUSY and (s_read|s_write) and !s_waitrequest; next state IDLE, pointer set to the other requester.
REQ-020 Outside BUSY, s_read=s_write=0; s_address/s_writedata/s_byteenable hold last value.
REQ-021 Minimum request-to-accept latency 1 cycle; maximum throughput one command per 2 cycles.
REQ-022 Accepted read pushes granted ID into tag FIFO; s_readdatavalid pops it and drives readdatavalid of that ID same cycle, readdata passed combinationally to both requesters.
REQ-023 Push and pop same cycle: occupancy unchanged, order preserved.
REQ-024 Tag FIFO full: reads ineligible, writes still granted; full never overflows.
REQ-025 s_readdatavalid with FIFO empty: no mN_readdatavalid, err set until reset.

Reset
REQ-026 Reset: state IDLE, pointer 0, FIFO empty, err 0, s_read=s_write=0, mN_readdatavalid=0, mN_waitrequest=1, s_address/s_writedata/s_byteenable 0.
REQ-027 Reset mid-transaction abandons the grant; read data returning after reset for pre-reset reads sets err.

Configuration
REQ-028 Macro SDRAM_ARB_FIXED_PRIO_EN defined: requester 0 always wins contention, pointer unused.
REQ-029 Macro undefined: round-robin per REQ-016/REQ-019.

Structure
REQ-030 Package sdram_arb_pkg holds state enum (IDLE, BUSY), default ADDR_W/DATA_W/TAG_DEPTH constants, requester-ID type.
REQ-031 Sub-module sdram_arb_tag_fifo: synchronous FIFO of 1-bit IDs, depth TAG_DEPTH, push/pop/full/empty.

Verification
REQ-032 m0 write addr 0x0000010 data 0xBEEF, s_waitrequest 0 -> s_write high one cycle after request, m0_waitrequest low that cycle, state IDLE after.
REQ-033 m0 and m1 both reading continuously, default build -> grants alternate 0,1,0,1; readdatavalid routed in matching order.
REQ-034 s_waitrequest held 3 cycles during m1 write -> s_* stable 4 cycles, m0 stalled throughout.
REQ-035 4 reads accepted, no return -> 5th read stalled, concurrent write from m1 accepted; one return then 5th read accepted.
REQ-036 s_readdatavalid with empty FIFO -> err=1, no mN_readdatavalid; reset -> err=0.
REQ-037 SDRAM_ARB_FIXED_PRIO_EN defined, both requesting continuously -> m0 granted every time, m1 stalled.
